matmul_skew_loader: RTL and testbench

Front-end writer for the matrix-multiply block. It accepts a start command with dimensions m, n and p. It then takes the elements of A (m×n) and B (n×p) in row-major order over a valid/ready stream and writes them into the diagonally skewed buffers that the matmul feeder consumes. Once both matrices are loaded, it drives the matmul enable until the matmul reports done, then flags the result as valid.

---
 rtl/matmul_skew_loader.sv | 138 +++++++++++++
 tb/tb_matmul_skew_loader.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_skew_loader.sv
// Front-end writer for the matmul: loads A (m x n) and B (n x p) from a stream
// into diagonally skewed buffers, then enables the matmul until it reports done.
module matmul_skew_loader #(
    parameter int BITS = 8,
    parameter int DIM  = 32,
    localparam int DW  = $clog2(DIM) + 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [DW-1:0]                           m_in,
    input  logic [DW-1:0]                           n_in,
    input  logic [DW-1:0]                           p_in,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [BITS-1:0]                         in_data,
    output logic [DW-1:0]                           m,
    output logic [DW-1:0]                           n,
    output logic [DW-1:0]                           p,
    output logic [DIM-1:0][DIM*2-2:0][BITS-1:0]     matrixDataA,
    output logic [DIM*2-2:0][DIM-1:0][BITS-1:0]     matrixDataB,
    output logic                                    mm_en,
    input  logic                                    mm_done,
    output logic                                    busy,
    output logic                                    result_valid,
    output logic                                    cfg_err
);

    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int IW = (DIM > 1) ? $clog2(DIM * 2 - 1) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, RUN} state_t;

    state_t        state;
    logic [AW-1:0] r;
    logic [AW-1:0] c;

    logic [DW-1:0] row_len;
    logic [DW-1:0] row_cnt;
    logic          last_col;
    logic          last_row;
    logic [IW-1:0] diag;
    logic          accept;
    logic          dims_ok;

    function automatic logic dim_ok(input logic [DW-1:0] d);
        return (d != '0) && (d <= DW'(DIM));
    endfunction

    // A is walked with n as row length and m rows; B with p as row length and n rows.
    always_comb begin
        row_len  = (state == LOAD_A) ? n : p;
        row_cnt  = (state == LOAD_A) ? m : n;
        last_col = (DW'(c) == row_len - DW'(1));
        last_row = (DW'(r) == row_cnt - DW'(1));
        diag     = IW'(DIM * 2 - 2) - IW'(r) - IW'(c);
        accept   = in_valid && in_ready;
        dims_ok  = dim_ok(m_in) && dim_ok(n_in) && dim_ok(p_in);
    end

    assign result_valid = (state == RUN) && mm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            c           <= '0;
            m           <= '0;
            n           <= '0;
            p           <= '0;
            // NOTE: the skew buffers are register arrays read directly by the matmul,
            // so they take the async reset; a RAM macro could not be cleared this way.
            matrixDataA <= '0;
            matrixDataB <= '0;
            in_ready    <= 1'b0;
            mm_en       <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            m     <= m_in;
                            n     <= n_in;
                            p     <= p_in;
                            busy  <= 1'b1;
                            state <= CLEAR;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    matrixDataA <= '0;
                    matrixDataB <= '0;
                    r           <= '0;
                    c           <= '0;
                    in_ready    <= 1'b1;
                    state       <= LOAD_A;
                end
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        if (state == LOAD_A) matrixDataA[r][diag] <= in_data;
                        else                 matrixDataB[diag][c] <= in_data;
                        if (last_col) begin
                            c <= '0;
                            if (last_row) begin
                                r <= '0;
                                if (state == LOAD_A) begin
                                    state <= LOAD_B;
                                end else begin
                                    in_ready <= 1'b0;
                                    mm_en    <= 1'b1;
                                    state    <= RUN;
                                end
                            end else begin
                                r <= r + AW'(1);
                            end
                        end else begin
                            c <= c + AW'(1);
                        end
                    end
                end
                RUN: begin
                    if (mm_done) begin
                        mm_en <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_skew_loader.sv
// Self-checking bench for matmul_skew_loader at DIM=4: scoreboard of expected
// buffer writes, drained and compared when mm_en rises.
module tb_matmul_skew_loader;
    localparam int BITS = 8;
    localparam int DIM  = 4;
    localparam int DW   = $clog2(DIM) + 1;
    localparam int DG   = 2 * DIM - 1;

    logic clk = 1'b0;
    logic rst_n, start, in_valid, in_ready, mm_en, mm_done, busy, result_valid, cfg_err;
    logic [DW-1:0] m_in, n_in, p_in, m, n, p;
    logic [BITS-1:0] in_data;
    logic [DIM-1:0][DG-1:0][BITS-1:0] matrixDataA, exp_a;
    logic [DG-1:0][DIM-1:0][BITS-1:0] matrixDataB, exp_b;

    typedef struct {
        bit             is_b;
        int             row;
        int             col;
        logic [BITS-1:0] data;
    } sb_t;

    sb_t             sb_q[$];
    logic [BITS-1:0] stim[$];
    int checks   = 0;
    int failures = 0;
    int cur_m, cur_n, cur_p;

    always #5 clk = ~clk;

    matmul_skew_loader #(.BITS(BITS), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .m_in(m_in), .n_in(n_in), .p_in(p_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .m(m), .n(n), .p(p),
        .matrixDataA(matrixDataA), .matrixDataB(matrixDataB),
        .mm_en(mm_en), .mm_done(mm_done), .busy(busy),
        .result_valid(result_valid), .cfg_err(cfg_err)
    );

    function automatic void model_start(input int mm, input int nn, input int pp);
        exp_a = '0;
        exp_b = '0;
        sb_q.delete();
        cur_m = mm;
        cur_n = nn;
        cur_p = pp;
    endfunction

    // Expected location of stream element idx, derived from row-major order.
    function automatic void sb_push(input int idx);
        sb_t e;
        int  k, j, b;
        e.data = stim[idx];
        if (idx < cur_m * cur_n) begin
            e.is_b = 1'b0;
            e.row  = idx / cur_n;
            k      = idx % cur_n;
            e.col  = 2 * DIM - 2 - e.row - k;
            exp_a[e.row][e.col] = e.data;
        end else begin
            b      = idx - cur_m * cur_n;
            k      = b / cur_p;
            j      = b % cur_p;
            e.is_b = 1'b1;
            e.row  = 2 * DIM - 2 - k - j;
            e.col  = j;
            exp_b[e.row][e.col] = e.data;
        end
        sb_q.push_back(e);
    endfunction

    task automatic sb_drain(input string tag);
        sb_t e;
        logic [BITS-1:0] got;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = e.is_b ? matrixDataB[e.row][e.col] : matrixDataA[e.row][e.col];
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s_%s[%0d][%0d] got=%0d exp=%0d", tag, e.is_b ? "B" : "A",
                         e.row, e.col, got, e.data);
            end
        end
    endtask

    task automatic compare_buffers(input string tag);
        checks++;
        if (matrixDataA !== exp_a) begin
            failures++;
            $display("FAIL %s_bufA got=%h exp=%h", tag, matrixDataA, exp_a);
        end
        checks++;
        if (matrixDataB !== exp_b) begin
            failures++;
            $display("FAIL %s_bufB got=%h exp=%h", tag, matrixDataB, exp_b);
        end
    endtask

    task automatic start_cmd(input int mm, input int nn, input int pp);
        @(negedge clk);
        start = 1'b1;
        m_in  = DW'(mm);
        n_in  = DW'(nn);
        p_in  = DW'(pp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers up to limit elements; bubbles gives the 1,0,0 valid pattern.
    task automatic stream(input int limit, input bit bubbles, output int hs,
                          output bit ready_drop, output logic mm_en_last);
        int   idx = 0;
        int   cyc = 0;
        bit   seen = 1'b0;
        logic v;
        hs = 0;
        ready_drop = 1'b0;
        mm_en_last = 1'bx;
        while (idx < limit && cyc < 200) begin
            @(negedge clk);
            v        = bubbles ? (cyc % 3 == 0) : 1'b1;
            in_valid = v;
            in_data  = v ? stim[idx] : BITS'($urandom);
            if (in_ready) seen = 1'b1;
            else if (seen) ready_drop = 1'b1;
            if (v && in_ready) begin
                sb_push(idx);
                idx++;
                hs++;
                mm_en_last = mm_en;
            end
            cyc++;
        end
    endtask

    task automatic finish_run();
        @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mm_en, busy, result_valid, cfg_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {in_ready, mm_en, busy, result_valid, cfg_err});
        end
        checks++;
        if ({m, n, p} !== '0) begin
            failures++;
            $display("FAIL reset_dims got=%0d/%0d/%0d exp=0/0/0", m, n, p);
        end
        model_start(0, 0, 0);
        compare_buffers("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b in_ready=%b exp=0/0", busy, in_ready);
        end
    endtask

    task automatic test_load_2x2x2(input string tag);
        int   hs;
        bit   drop;
        logic mm_last;
        model_start(2, 2, 2);
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        start_cmd(2, 2, 2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_clear busy=%b in_ready=%b exp=1/0", tag, busy, in_ready);
        end
        checks++;
        if ({m, n, p} !== {DW'(2), DW'(2), DW'(2)}) begin
            failures++;
            $display("FAIL %s_dims got=%0d/%0d/%0d exp=2/2/2", tag, m, n, p);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_latency got=%b exp=1", tag, in_ready);
        end
        stream(8, 1'b0, hs, drop, mm_last);
        checks++;
        if (hs !== 8) begin
            failures++;
            $display("FAIL %s_handshakes got=%0d exp=8", tag, hs);
        end
        checks++;
        if (mm_last !== 1'b0) begin
            failures++;
            $display("FAIL %s_mm_en_early got=%b exp=0", tag, mm_last);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mm_en !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_run_entry mm_en=%b in_ready=%b exp=1/0", tag, mm_en, in_ready);
        end
        checks++;
        if ({matrixDataA[0][6], matrixDataA[1][4], matrixDataB[5][0], matrixDataB[4][1]} !==
            {8'd1, 8'd4, 8'd7, 8'd8}) begin
            failures++;
            $display("FAIL %s_corners got=%h exp=01040708", tag,
                     {matrixDataA[0][6], matrixDataA[1][4], matrixDataB[5][0], matrixDataB[4][1]});
        end
        sb_drain(tag);
        compare_buffers(tag);
    endtask

    task automatic test_complete();
        @(negedge clk);
        start = 1'b1;
        m_in  = DW'(1);
        n_in  = DW'(1);
        p_in  = DW'(1);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mm_en !== 1'b1 || busy !== 1'b1 || cfg_err !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stray_start mm_en=%b busy=%b cfg_err=%b in_ready=%b exp=1/1/0/0",
                     mm_en, busy, cfg_err, in_ready);
        end
        checks++;
        if ({m, n, p} !== {DW'(2), DW'(2), DW'(2)}) begin
            failures++;
            $display("FAIL stray_dims got=%0d/%0d/%0d exp=2/2/2", m, n, p);
        end
        mm_done = 1'b1;
        #1;
        checks++;
        if (result_valid !== 1'b1) begin
            failures++;
            $display("FAIL done_result_valid got=%b exp=1", result_valid);
        end
        @(negedge clk);
        checks++;
        if ({result_valid, mm_en, busy} !== 3'b000) begin
            failures++;
            $display("FAIL done_idle rv/mm_en/busy got=%b exp=000", {result_valid, mm_en, busy});
        end
        mm_done = 1'b0;
        compare_buffers("done_retain");
    endtask

    task automatic test_illegal();
        logic [DW-1:0] bad_n[2] = '{DW'(0), DW'(2)};
        logic [DW-1:0] bad_p[2] = '{DW'(2), DW'(DIM + 1)};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1;
            m_in  = DW'(2);
            n_in  = bad_n[i];
            p_in  = bad_p[i];
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d_pulse cfg_err=%b busy=%b exp=1/0", i, cfg_err, busy);
            end
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d_once cfg_err=%b busy=%b exp=0/0", i, cfg_err, busy);
            end
        end
        checks++;
        if ({m, n, p} !== {DW'(2), DW'(2), DW'(2)}) begin
            failures++;
            $display("FAIL illegal_dims got=%0d/%0d/%0d exp=2/2/2", m, n, p);
        end
        compare_buffers("illegal");
    endtask

    task automatic test_backpressure();
        int   hs;
        bit   drop;
        logic mm_last;
        model_start(2, 2, 2);
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        start_cmd(2, 2, 2);
        stream(8, 1'b1, hs, drop, mm_last);
        checks++;
        if (hs !== 8) begin
            failures++;
            $display("FAIL bp_handshakes got=%0d exp=8", hs);
        end
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_drop got=%b exp=0", drop);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mm_en !== 1'b1) begin
            failures++;
            $display("FAIL bp_mm_en got=%b exp=1", mm_en);
        end
        sb_drain("bp");
        compare_buffers("bp");
        finish_run();
    endtask

    task automatic test_non_square();
        int   hs;
        bit   drop;
        logic mm_last;
        model_start(3, 1, 2);
        stim = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
        start_cmd(3, 1, 2);
        stream(5, 1'b0, hs, drop, mm_last);
        checks++;
        if (hs !== 5) begin
            failures++;
            $display("FAIL ns_handshakes got=%0d exp=5", hs);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_data = 8'hEE;
            checks++;
            if (in_ready !== 1'b0 || mm_en !== 1'b1) begin
                failures++;
                $display("FAIL ns_run%0d in_ready=%b mm_en=%b exp=0/1", i, in_ready, mm_en);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (matrixDataA[2][4] !== 8'd11) begin
            failures++;
            $display("FAIL ns_a24 got=%0d exp=11", matrixDataA[2][4]);
        end
        sb_drain("ns");
        compare_buffers("ns");
        finish_run();
    endtask

    task automatic test_reset_mid_load();
        int   hs;
        bit   drop;
        logic mm_last;
        model_start(2, 2, 2);
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        start_cmd(2, 2, 2);
        stream(3, 1'b0, hs, drop, mm_last);
        @(posedge clk);
        #2;
        checks++;
        if ({matrixDataA[0][6], matrixDataA[0][5], matrixDataA[1][5]} !== {8'd1, 8'd2, 8'd3}) begin
            failures++;
            $display("FAIL rml_partial got=%h exp=010203",
                     {matrixDataA[0][6], matrixDataA[0][5], matrixDataA[1][5]});
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready, mm_en, busy, result_valid, cfg_err} !== 5'b0 || {m, n, p} !== '0) begin
            failures++;
            $display("FAIL rml_outputs flags=%b dims=%0d/%0d/%0d exp=00000 0/0/0",
                     {in_ready, mm_en, busy, result_valid, cfg_err}, m, n, p);
        end
        model_start(0, 0, 0);
        compare_buffers("rml_zero");
        @(negedge clk);
        rst_n = 1'b1;
        test_load_2x2x2("reload");
        finish_run();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        m_in     = '0;
        n_in     = '0;
        p_in     = '0;
        in_valid = 1'b0;
        in_data  = '0;
        mm_done  = 1'b0;
        test_reset();
        test_load_2x2x2("b2b");
        test_complete();
        test_illegal();
        test_backpressure();
        test_non_square();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
